// File: rtl/run_monitor_pkg.sv
// rtl/run_monitor_pkg.sv - shared state encoding and report text for the end-of-run monitor
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DONE_HALT = 2'd2,
    ST_DONE_TO   = 2'd3
  } state_e;

  // Report text is split around the number so the format string stays a literal
  localparam string RPT_HALT_PRE = "Finished with << ";
  localparam string RPT_HALT_SUF = " >>";
  localparam string RPT_TO_PRE   = "ran for ";
  localparam string RPT_TO_SUF   = " cycles";
  localparam string RPT_EVT_PRE  = "evt[";

  function automatic logic is_counting(input state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/run_monitor_sat_counter.sv
// rtl/run_monitor_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter
  import run_monitor_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = &r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && inc && !w_at_max) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - cycle/event counters, halt/timeout detection and optional end-of-run report
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 500000,
  parameter int N_EVT      = 4,
  parameter int HALT_DRAIN = 2,
  parameter int FINISH_EN  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   is_halt,
  input  logic [31:0]            ret_val,
  input  logic [N_EVT-1:0]       evt,
  output logic                   done,
  output logic                   timed_out,
  output logic [31:0]            ret_latched,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [N_EVT*CNT_W-1:0] evt_count
);

  localparam int DRN_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [DRN_W-1:0] DRN_INIT = (HALT_DRAIN > 0) ? DRN_W'(HALT_DRAIN - 1) : '0;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  logic [DRN_W-1:0] r_drain_cnt;
  logic [31:0]      r_ret;
  logic             r_done;
  logic             r_timed_out;

  logic             w_cnt_en;
  logic             w_to_hit;
  logic [CNT_W-1:0] w_cycle;

  assign w_cnt_en = is_counting(r_state);
  // Timeout fires on the edge that carries the cycle counter onto TIMEOUT
  assign w_to_hit = (w_cycle == TO_LAST);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (w_cnt_en),
    .inc   (1'b1),
    .q     (w_cycle)
  );

  genvar g;
  generate
    for (g = 0; g < N_EVT; g++) begin : g_evt
      sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (w_cnt_en),
        .inc   (evt[g]),
        .q     (evt_count[g*CNT_W +: CNT_W])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_ret       <= '0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
    end else if (clr) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_ret       <= '0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (is_halt) begin
            r_ret <= ret_val;
            if (HALT_DRAIN == 0) begin
              r_state <= ST_DONE_HALT;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= DRN_INIT;
            end
          end else if (w_to_hit) begin
            r_state     <= ST_DONE_TO;
            r_done      <= 1'b1;
            r_timed_out <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= ST_DONE_HALT;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done        = r_done;
  assign timed_out   = r_timed_out;
  assign ret_latched = r_ret;
  assign cycle_count = w_cycle;

`ifndef SYNTHESIS
  // Report one edge after done rises so ret_latched already holds the halt value
  logic r_done_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= r_done;
      if ((FINISH_EN != 0) && r_done && !r_done_q) begin
        if (r_timed_out)
          $display("%s%0d%s", RPT_TO_PRE, TIMEOUT, RPT_TO_SUF);
        else
          $display("%s%0d%s", RPT_HALT_PRE, r_ret, RPT_HALT_SUF);
        for (int i = 0; i < N_EVT; i++)
          $display("%s%0d] = %0d", RPT_EVT_PRE, i, evt_count[i*CNT_W +: CNT_W]);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_run_monitor.sv
// tb/tb_run_monitor.sv - directed self-checking bench for run_monitor
module tb_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // u_a: CNT_W=32, TIMEOUT=100, N_EVT=3, HALT_DRAIN=2
  logic        rst_a, clr_a, halt_a;
  logic [31:0] ret_a;
  logic [2:0]  evt_a;
  logic        done_a, to_a;
  logic [31:0] retl_a, cyc_a;
  logic [95:0] evc_a;

  run_monitor #(.CNT_W(32), .TIMEOUT(100), .N_EVT(3), .HALT_DRAIN(2), .FINISH_EN(0)) u_a (
    .clk(clk), .rst_n(rst_a), .clr(clr_a), .is_halt(halt_a), .ret_val(ret_a), .evt(evt_a),
    .done(done_a), .timed_out(to_a), .ret_latched(retl_a), .cycle_count(cyc_a), .evt_count(evc_a)
  );

  // u_b: halt and timeout on the same edge, no drain window
  logic        rst_b, clr_b, halt_b;
  logic [31:0] ret_b;
  logic [0:0]  evt_b;
  logic        done_b, to_b;
  logic [31:0] retl_b;
  logic [7:0]  cyc_b, evc_b;

  run_monitor #(.CNT_W(8), .TIMEOUT(50), .N_EVT(1), .HALT_DRAIN(0), .FINISH_EN(0)) u_b (
    .clk(clk), .rst_n(rst_b), .clr(clr_b), .is_halt(halt_b), .ret_val(ret_b), .evt(evt_b),
    .done(done_b), .timed_out(to_b), .ret_latched(retl_b), .cycle_count(cyc_b), .evt_count(evc_b)
  );

  // u_c: narrow counters driven past their ceiling by a long drain
  logic        rst_c, clr_c, halt_c;
  logic [31:0] ret_c;
  logic [0:0]  evt_c;
  logic        done_c, to_c;
  logic [31:0] retl_c;
  logic [3:0]  cyc_c, evc_c;

  run_monitor #(.CNT_W(4), .TIMEOUT(15), .N_EVT(1), .HALT_DRAIN(6), .FINISH_EN(0)) u_c (
    .clk(clk), .rst_n(rst_c), .clr(clr_c), .is_halt(halt_c), .ret_val(ret_c), .evt(evt_c),
    .done(done_c), .timed_out(to_c), .ret_latched(retl_c), .cycle_count(cyc_c), .evt_count(evc_c)
  );

  initial begin
    rst_a = 1'b0; clr_a = 1'b0; halt_a = 1'b0; ret_a = '0; evt_a = '0;
    rst_b = 1'b0; clr_b = 1'b0; halt_b = 1'b0; ret_b = '0; evt_b = '0;
    rst_c = 1'b0; clr_c = 1'b0; halt_c = 1'b0; ret_c = '0; evt_c = '0;
    repeat (3) tick();

    check("rst_done",  done_a, 0);
    check("rst_to",    to_a,   0);
    check("rst_cycle", cyc_a,  0);
    check("rst_ret",   retl_a, 0);
    check("rst_evt",   evc_a,  0);

    // Halt at edge 10 (ret 42), second halt at edge 11 (ret 7) must be ignored
    rst_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      evt_a  = {1'b0, (k % 2 == 0), 1'b1};
      halt_a = (k == 10) || (k == 11);
      ret_a  = (k == 10) ? 32'd42 : ((k == 11) ? 32'd7 : 32'd0);
      tick();
      if (k == 1)  check("first_edge_cycle", cyc_a, 1);
      if (k == 10) check("halt_ret_latch", retl_a, 42);
      if (k == 11) check("drain_not_done", done_a, 0);
    end
    halt_a = 1'b0;
    check("halt_done",      done_a, 1);
    check("halt_not_to",    to_a,   0);
    check("halt_ret_kept",  retl_a, 42);
    check("halt_cycle",     cyc_a,  12);
    check("evt0_count",     evc_a[31:0],  12);
    check("evt1_count",     evc_a[63:32], 6);
    check("evt2_count",     evc_a[95:64], 0);
    repeat (3) tick();
    check("frozen_cycle",   cyc_a,        12);
    check("frozen_evt0",    evc_a[31:0],  12);
    check("still_done",     done_a,       1);

    // clr from DONE_HALT, then async reset in the middle of DRAIN
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("clr_cycle", cyc_a,  0);
    check("clr_done",  done_a, 0);
    check("clr_ret",   retl_a, 0);
    check("clr_evt",   evc_a,  0);
    evt_a = '0; halt_a = 1'b1; ret_a = 32'd5;
    tick();
    halt_a = 1'b0;
    check("drain_ret", retl_a, 5);
    rst_a = 1'b0;
    #1;
    check("async_rst_ret",   retl_a, 0);
    check("async_rst_cycle", cyc_a,  0);
    check("async_rst_done",  done_a, 0);
    rst_a = 1'b1;

    // Timeout with no halt
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 99) check("pre_timeout_done", done_a, 0);
    end
    check("timeout_done",  done_a, 1);
    check("timeout_flag",  to_a,   1);
    check("timeout_cycle", cyc_a,  100);
    repeat (3) tick();
    check("timeout_frozen", cyc_a, 100);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("clr_to_cycle", cyc_a, 0);
    check("clr_to_flag",  to_a,  0);
    tick();
    check("rerun_cycle",  cyc_a, 1);

    // Halt on the timeout edge wins
    rst_b = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      halt_b = (k == 50);
      ret_b  = 32'd99;
      tick();
      if (k == 49) check("b_pre_done", done_b, 0);
    end
    halt_b = 1'b0;
    check("b_done",  done_b, 1);
    check("b_to",    to_b,   0);
    check("b_ret",   retl_b, 99);
    check("b_cycle", cyc_b,  50);
    repeat (2) tick();
    check("b_to_hold", to_b, 0);

    // Saturation during a long drain; timeout not checked in DRAIN
    evt_c = 1'b1;
    rst_c = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      halt_c = (k == 12) || (k == 13);
      ret_c  = (k == 12) ? 32'd3 : 32'd7;
      tick();
      if (k == 16) begin
        check("c_sat_cycle", cyc_c,  15);
        check("c_drain_to",  to_c,   0);
        check("c_drain_dn",  done_c, 0);
      end
      if (k == 17) check("c_pre_done", done_c, 0);
    end
    halt_c = 1'b0;
    check("c_done",     done_c, 1);
    check("c_to",       to_c,   0);
    check("c_ret",      retl_c, 3);
    check("c_evt_sat",  evc_c,  15);
    check("c_cyc_sat",  cyc_c,  15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Parametrised end-of-run monitor for the processor testbench top. It counts cycles and up to N_EVT performance events, and detects core halt with an optional pipeline-drain window. It latches the program return value and declares a halt or timeout outcome, with an optional simulation `$display`/`$finish` report. Counters and status are synthesizable; the report is the only simulation-only part.

## Interface
Parameters:
- CNT_W, 32, width of cycle and event counters
- TIMEOUT, 500000, cycle count at which the run is declared timed out (must be < 2^CNT_W)
- N_EVT, 4, number of event counter channels (≥1)
- HALT_DRAIN, 2, cycles to wait after halt before declaring done (0 = immediate)
- FINISH_EN, 1, 1 = print report and call $finish on done; 0 = status outputs only

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: counters to 0, FSM to RUN
- is_halt  in  1  halt retire strobe from writeback
- ret_val  in  32  program return value, sampled with is_halt
- evt  in  N_EVT  per-cycle event strobes (retire, stall, flush, ...)
- done  out  1  run finished (halt or timeout)
- timed_out  out  1  finished by timeout
- ret_latched  out  32  ret_val captured at halt
- cycle_count  out  CNT_W  cycles counted
- evt_count  out  N_EVT*CNT_W  event counters, channel i at [i*CNT_W +: CNT_W]

## Operation
- FSM states: RUN, DRAIN, DONE_HALT, DONE_TO.
- RUN: cycle_count += 1 per cycle; evt_count[i] += evt[i].
  - is_halt=1 → latch ret_val; go to DRAIN with drain_cnt=HALT_DRAIN-1, or to DONE_HALT if HALT_DRAIN=0.
  - Otherwise, cycle_count==TIMEOUT → DONE_TO.
- DRAIN: counters keep counting; further is_halt ignored (ret_latched holds first value); drain_cnt==0 → DONE_HALT, else decrement. Timeout is not checked in DRAIN.
- DONE_HALT / DONE_TO: all counters frozen; states are absorbing until clr or reset.
- Priority per edge: clr > is_halt > timeout. Halt and timeout on the same cycle → halt wins.
- All counters saturate at 2^CNT_W−1; no wrap.
- done = state ∈ {DONE_HALT, DONE_TO}; timed_out = state==DONE_TO.
- FINISH_EN=1, simulation only. On the edge entering a DONE state:
  - DONE_HALT: print "Finished with << %0d >>" with ret_latched.
  - DONE_TO: print "ran for %0d cycles" with TIMEOUT.
  - Then print each event count and call $finish.

## Timing
- Reset (rst_n low, asynchronous) drives: state=RUN, cycle_count=0, evt_count=0, ret_latched=0, drain_cnt=0. Outputs done=0, timed_out=0.
- First rising edge after rst_n deasserts: cycle_count 0→1.
- Halt latency: is_halt high at edge k → done high after edge k+HALT_DRAIN (HALT_DRAIN=0: after edge k).
- Timeout: done and timed_out go high after the edge at which cycle_count==TIMEOUT; cycle_count reads TIMEOUT, not incremented further.
- clr is sampled at the edge; outputs are zero after that edge. It acts from any state, including DRAIN.
- Reset mid-run or mid-DRAIN discards all state immediately; no report is printed.
- All outputs are registered; no combinational input→output paths.

## Structure
- Package run_monitor_pkg holds the state encoding constants (RUN=2'd0, DRAIN=2'd1, DONE_HALT=2'd2, DONE_TO=2'd3) and the report string formats.
- Sub-module sat_counter (param W; inputs clk, rst_n, clr, en, inc; output q) is instantiated once for cycles and N_EVT times via generate. Enable is state ∈ {RUN, DRAIN}.
- The report block sits under `ifndef SYNTHESIS` and is gated by FINISH_EN.

## Test plan
- Reset then is_halt at cycle 10 with ret_val=42, HALT_DRAIN=2 → done after edge 12, ret_latched=42, timed_out=0, report "Finished with << 42 >>".
- No halt, TIMEOUT=100 → done=timed_out=1 after edge 100, cycle_count=100 frozen thereafter.
- is_halt and cycle_count==TIMEOUT on the same edge (TIMEOUT=50, HALT_DRAIN=0) → DONE_HALT, timed_out=0.
- CNT_W=4, evt[0] held high with TIMEOUT=15 → evt_count[0] saturates at 15 and does not wrap; second is_halt in DRAIN with ret_val=7 leaves ret_latched unchanged.
- Assert rst_n low mid-DRAIN → all outputs 0 immediately, no $finish; then clr in DONE_TO → back to RUN with counters 0 next cycle.
- FINISH_EN=0, N_EVT=3 with distinct evt patterns → per-channel counts match the bench model and the simulation keeps running after done.
